pll_mode_reconfig: RTL and testbench
====================================

// Module: pll_mode_reconfig
// PURPOSE
//  Sequencer that reprograms the system PLL through its Avalon-MM reconfig port whenever the
//  selected video mode changes. Supports NUM_MODES modes (NTSC/PAL and beyond) and any
//  per-mode write count. Holds the core in reset while the PLL is retuned.
//  Sits in the top-level emu, between the OSD status bits and the pll_cfg management port.
// PARAMETERS
//  NUM_MODES     2     number of selectable modes
//  MODE_W        1     width of mode index; 2**MODE_W >= NUM_MODES
//  NUM_WRITES    4     table writes per mode (counter/frac registers), excluding arm and start writes
//  IDX_W         3     width of table index; 2**IDX_W >= NUM_WRITES
//  SYNC_STAGES   2     flops in the mode_in synchroniser (>=2)
//  RESET_MODE    0     mode the PLL powers up in; no sequence runs while mode equals it
//  LOCK_TIMEOUT  65535 max cycles waited for pll_locked (lock-wait build only)
//  SETTLE_CYCLES 1024  fixed settle delay after the start write (no lock-wait build)
// PORTS
//  clk              in   1      system clock
//  reset            in   1      synchronous, active-high reset
//  mode_in          in   MODE_W requested mode; asynchronous to clk
//  tbl_mode         out  MODE_W mode index driving the parent's write table
//  tbl_idx          out  IDX_W  entry index driving the parent's write table
//  tbl_addr         in   6      table register address for (tbl_mode, tbl_idx); combinational
//  tbl_data         in   32     table register data for (tbl_mode, tbl_idx); combinational
//  mgmt_write       out  1      Avalon write strobe
//  mgmt_address     out  6      Avalon address
//  mgmt_writedata   out  32     Avalon write data
//  mgmt_waitrequest in   1      Avalon wait request
//  pll_locked       in   1      PLL lock indicator
//  core_reset       out  1      reset to the core; high from arm write until sequence end
//  busy             out  1      high in every state except IDLE
//  cur_mode         out  MODE_W mode the PLL is currently programmed to
//  lock_err         out  1      sticky; set on lock timeout, cleared only by reset
// BEHAVIOUR
//  Reset values: mgmt_write=0, mgmt_address=0, mgmt_writedata=0, core_reset=0, busy=0,
//   lock_err=0, cur_mode=RESET_MODE, tbl_idx=0, tbl_mode=RESET_MODE.
//   The synchroniser flops reset to RESET_MODE.
//  Reset mid-sequence aborts immediately to IDLE with the reset values. The PLL is left
//   partly programmed; cur_mode=RESET_MODE, so a differing mode_in reruns a full sequence.
//  mode_s is mode_in after SYNC_STAGES flops. Values >= NUM_MODES are ignored; the
//   previous valid mode_s is kept.
//  States:
//   IDLE: if mode_s!=cur_mode, latch tgt=mode_s, set tbl_mode=tgt, go ARM.
//   ARM: write addr 0, data 0 (waitrequest mode); core_reset=1. Go TBL.
//   TBL: write {tbl_addr,tbl_data} for tbl_idx 0..NUM_WRITES-1; go START after the last entry.
//   START: write addr 2, data 0; go LOCK (or SETTLE).
//   LOCK: ignore pll_locked for 8 cycles, then go DONE on pll_locked=1.
//         If LOCK_TIMEOUT cycles pass in LOCK, set lock_err and go DONE.
//   DONE: cur_mode<=tgt; core_reset<=0; go IDLE.
//  Write handshake:
//   - mgmt_write, address and data are registered and held stable while mgmt_waitrequest=1.
//   - A write is accepted on the edge where mgmt_write=1 and mgmt_waitrequest=0.
//   - The next write, if any, is presented on the following cycle.
//   - With waitrequest held low, writes occur back-to-back: NUM_WRITES+2 consecutive cycles.
//  Latency: a mode_s change seen in IDLE on cycle n gives mgmt_write=1 (ARM) on cycle n+1.
//  Mode changes during busy: tgt is not updated and the sequence completes.
//   IDLE then compares mode_s with cur_mode again, so a later mode runs a new sequence.
//   Toggling mode A->B->A during busy leaves one sequence for B, then one back to A.
//  tbl_idx wraps to 0 on leaving TBL. tbl_mode is stable for the whole sequence.
// CONFIGURATION
//  PLLCFG_LOCK_WAIT_EN defined: the LOCK state is as above and lock_err is live.
//  Not defined: START goes to SETTLE, which waits SETTLE_CYCLES cycles and then goes to DONE.
//   pll_locked is ignored and lock_err is tied to 0.
// TESTING
//  1. Reset, mode_in=0=RESET_MODE, 200 cycles -> mgmt_write never asserted, busy=0.
//  2. mode_in 0->1, waitrequest=0 -> 6 consecutive writes: addr 0/data 0, table 1:0..1:3,
//     addr 2/data 0. core_reset high throughout, cur_mode=1 after lock.
//  3. waitrequest high 3 cycles on 2nd table write -> address/data held 4 cycles, no skipped
//     or duplicated write.
//  4. mode 0->1, then 1->0 during TBL -> full sequence to 1, then full sequence to 0.
//     Final cur_mode=0.
//  5. Lock-wait build, pll_locked stuck 0, LOCK_TIMEOUT=100 -> lock_err=1 after 100 cycles
//     in LOCK. core_reset drops and lock_err stays 1.
//  6. Reset asserted during TBL -> next cycle all outputs at reset values.
//     With mode_in=1, the sequence restarts from ARM.

Source files
------------

// File: rtl/pll_mode_reconfig.sv
// Purpose : reprograms the system PLL over its Avalon-MM reconfig port when the selected video mode changes,
//           holding the core in reset for the whole retune.
// Latency : mode_s change seen in IDLE on cycle n -> first (arm) write presented on cycle n+1.
// Backpressure: each write is held (strobe, address, data) while mgmt_waitrequest=1; the next write follows the accepting edge.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   mode_in               requested mode (asynchronous, synchronised here)
//   tbl_mode/tbl_idx      index into the parent's write table; tbl_addr/tbl_data come back combinationally
//   mgmt_*                Avalon-MM master toward the PLL reconfig block
//   pll_locked            PLL lock indicator (lock-wait build only)
//   core_reset, busy      core hold-off and sequencer activity
//   cur_mode, lock_err    mode currently programmed; sticky lock-timeout flag
//
// Build option: define PLLCFG_LOCK_WAIT_EN to wait for pll_locked (with timeout) instead of a fixed settle delay.
module pll_mode_reconfig #(
  parameter int NUM_MODES     = 2,
  parameter int MODE_W        = 1,
  parameter int NUM_WRITES    = 4,
  parameter int IDX_W         = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int RESET_MODE    = 0,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_in,
  output logic [MODE_W-1:0] tbl_mode,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [5:0]        tbl_addr,
  input  logic [31:0]       tbl_data,
  output logic              mgmt_write,
  output logic [5:0]        mgmt_address,
  output logic [31:0]       mgmt_writedata,
  input  logic              mgmt_waitrequest,
  input  logic              pll_locked,
  output logic              core_reset,
  output logic              busy,
  output logic [MODE_W-1:0] cur_mode,
  output logic              lock_err
);

  localparam logic [MODE_W-1:0] RST_M    = MODE_W'(RESET_MODE);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_WRITES - 1);
  localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_TBL, S_START, S_LOCK, S_SETTLE, S_DONE
  } state_t;

  // Synchroniser. The final stage only loads in-range modes, so an out-of-range
  // request leaves the previous valid mode in place.
  logic [SYNC_STAGES-1:0][MODE_W-1:0] sync_q;
  logic [MODE_W-1:0] mode_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_M}};
    end else begin
      sync_q[0] <= mode_in;
      for (int i = 1; i < SYNC_STAGES - 1; i++) sync_q[i] <= sync_q[i-1];
      if (int'(sync_q[SYNC_STAGES-2]) < NUM_MODES)
        sync_q[SYNC_STAGES-1] <= sync_q[SYNC_STAGES-2];
    end
  end

  assign mode_s = sync_q[SYNC_STAGES-1];

  state_t            state, nxt_state;
  logic              nxt_write, nxt_core_reset;
  logic [5:0]        nxt_addr;
  logic [31:0]       nxt_data;
  logic [MODE_W-1:0] tgt, nxt_tgt, nxt_cur_mode, nxt_tbl_mode;
  logic [IDX_W-1:0]  nxt_tbl_idx;
  logic              last_ent, nxt_last;   // entry on the bus is the final table write
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  logic              accept;

  assign accept = mgmt_write & ~mgmt_waitrequest;
  assign busy   = (state != S_IDLE);

`ifdef PLLCFG_LOCK_WAIT_EN
  logic lock_q, nxt_lock_err;
  assign lock_err = lock_q;
`else
  logic pll_locked_unused;
  assign pll_locked_unused = pll_locked;
  assign lock_err = 1'b0;
`endif

  always_comb begin
    nxt_state      = state;
    nxt_write      = mgmt_write;
    nxt_addr       = mgmt_address;
    nxt_data       = mgmt_writedata;
    nxt_core_reset = core_reset;
    nxt_cur_mode   = cur_mode;
    nxt_tgt        = tgt;
    nxt_tbl_mode   = tbl_mode;
    nxt_tbl_idx    = tbl_idx;
    nxt_last       = last_ent;
    nxt_cnt        = cnt;
`ifdef PLLCFG_LOCK_WAIT_EN
    nxt_lock_err   = lock_q;
`endif
    case (state)
      S_IDLE: begin
        if (mode_s != cur_mode) begin
          nxt_tgt        = mode_s;
          nxt_tbl_mode   = mode_s;
          nxt_state      = S_ARM;
          nxt_write      = 1'b1;
          nxt_addr       = 6'd0;
          nxt_data       = 32'd0;
          nxt_core_reset = 1'b1;
        end
      end
      // The table entry for tbl_idx is captured on the accepting edge and tbl_idx
      // advances at the same time, so table writes can go back-to-back.
      S_ARM, S_TBL: begin
        if (accept) begin
          if (state == S_TBL && last_ent) begin
            nxt_state = S_START;
            nxt_addr  = 6'd2;
            nxt_data  = 32'd0;
            nxt_last  = 1'b0;
          end else begin
            nxt_state   = S_TBL;
            nxt_addr    = tbl_addr;
            nxt_data    = tbl_data;
            nxt_last    = (tbl_idx == IDX_LAST);
            nxt_tbl_idx = (tbl_idx == IDX_LAST) ? '0 : tbl_idx + IDX_W'(1);
          end
        end
      end
      S_START: begin
        if (accept) begin
          nxt_write = 1'b0;
          nxt_addr  = 6'd0;
          nxt_data  = 32'd0;
          nxt_cnt   = '0;
`ifdef PLLCFG_LOCK_WAIT_EN
          nxt_state = S_LOCK;
`else
          nxt_state = S_SETTLE;
`endif
        end
      end
`ifdef PLLCFG_LOCK_WAIT_EN
      // cnt holds the number of cycles already spent here; lock is not trusted
      // during the first 8.
      S_LOCK: begin
        nxt_cnt = cnt + CNT_W'(1);
        if (cnt >= CNT_W'(8) && pll_locked) begin
          nxt_state = S_DONE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          nxt_lock_err = 1'b1;
          nxt_state    = S_DONE;
        end
      end
`else
      S_SETTLE: begin
        nxt_cnt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) nxt_state = S_DONE;
      end
`endif
      S_DONE: begin
        nxt_cur_mode   = tgt;
        nxt_core_reset = 1'b0;
        nxt_state      = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      mgmt_write     <= 1'b0;
      mgmt_address   <= 6'd0;
      mgmt_writedata <= 32'd0;
      core_reset     <= 1'b0;
      cur_mode       <= RST_M;
      tgt            <= RST_M;
      tbl_mode       <= RST_M;
      tbl_idx        <= '0;
      last_ent       <= 1'b0;
      cnt            <= '0;
    end else begin
      state          <= nxt_state;
      mgmt_write     <= nxt_write;
      mgmt_address   <= nxt_addr;
      mgmt_writedata <= nxt_data;
      core_reset     <= nxt_core_reset;
      cur_mode       <= nxt_cur_mode;
      tgt            <= nxt_tgt;
      tbl_mode       <= nxt_tbl_mode;
      tbl_idx        <= nxt_tbl_idx;
      last_ent       <= nxt_last;
      cnt            <= nxt_cnt;
    end
  end

`ifdef PLLCFG_LOCK_WAIT_EN
  always_ff @(posedge clk) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= nxt_lock_err;
  end
`endif

endmodule

// File: tb/tb_pll_mode_reconfig.sv
module tb_pll_mode_reconfig;

  localparam int NUM_MODES     = 3;
  localparam int MODE_W        = 2;
  localparam int NUM_WRITES    = 4;
  localparam int IDX_W         = 3;
  localparam int SYNC_STAGES   = 2;
  localparam int RESET_MODE    = 0;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int SETTLE_CYCLES = 20;
  // busy cycles for one sequence: ARM + 4 TBL + START + wait + DONE
`ifdef PLLCFG_LOCK_WAIT_EN
  localparam int SEQ_CYC = 1 + 4 + 1 + 9 + 1;
`else
  localparam int SEQ_CYC = 1 + 4 + 1 + SETTLE_CYCLES + 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [MODE_W-1:0] mode_in;
  logic [MODE_W-1:0] tbl_mode;
  logic [IDX_W-1:0]  tbl_idx;
  logic [5:0]        tbl_addr;
  logic [31:0]       tbl_data;
  logic              mgmt_write;
  logic [5:0]        mgmt_address;
  logic [31:0]       mgmt_writedata;
  logic              mgmt_waitrequest;
  logic              pll_locked;
  logic              core_reset;
  logic              busy;
  logic [MODE_W-1:0] cur_mode;
  logic              lock_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Parent write table: address 8 + 8*mode + idx, data C0DE_{mode}{idx}
  assign tbl_addr = 6'd8 + {1'b0, tbl_mode, 3'b000} + {3'b000, tbl_idx};
  assign tbl_data = {16'hC0DE, 6'b0, tbl_mode, 5'b0, tbl_idx};

  // Hand-written expected write sequences for mode 0 and mode 1
  int          exp_a [2][6] = '{'{0, 8, 9, 10, 11, 2}, '{0, 16, 17, 18, 19, 2}};
  logic [31:0] exp_d [2][6] = '{'{32'h0, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'h0},
                                '{32'h0, 32'hC0DE0100, 32'hC0DE0101, 32'hC0DE0102, 32'hC0DE0103, 32'h0}};

  pll_mode_reconfig #(
    .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .NUM_WRITES(NUM_WRITES), .IDX_W(IDX_W),
    .SYNC_STAGES(SYNC_STAGES), .RESET_MODE(RESET_MODE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .mode_in(mode_in),
    .tbl_mode(tbl_mode), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .mgmt_write(mgmt_write), .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
    .core_reset(core_reset), .busy(busy), .cur_mode(cur_mode), .lock_err(lock_err)
  );

  // Bus monitor: records every accepted write, sampled on the falling edge
  logic [5:0]  wq_addr [$];
  logic [31:0] wq_data [$];
  int          wq_cyc  [$];
  int cyc = 0, busy_cnt = 0, cr_mis = 0, wr_seen = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mgmt_write && !mgmt_waitrequest) begin
      wq_addr.push_back(mgmt_address);
      wq_data.push_back(mgmt_writedata);
      wq_cyc.push_back(cyc);
    end
    if (mgmt_write) wr_seen <= wr_seen + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (core_reset !== busy) cr_mis <= cr_mis + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int w0, b0;
    reset = 1'b1; mode_in = 2'd0; mgmt_waitrequest = 1'b0; pll_locked = 1'b1;
    repeat (3) step();
    checks++; if (mgmt_write !== 1'b0) begin failures++; $display("FAIL rst_write got %b want 0", mgmt_write); end
    checks++; if (mgmt_address !== 6'd0) begin failures++; $display("FAIL rst_addr got %0d want 0", mgmt_address); end
    checks++; if (mgmt_writedata !== 32'd0) begin failures++; $display("FAIL rst_data got %h want 0", mgmt_writedata); end
    checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL rst_core_reset got %b want 0", core_reset); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (lock_err !== 1'b0) begin failures++; $display("FAIL rst_lock_err got %b want 0", lock_err); end
    checks++; if (cur_mode !== 2'd0) begin failures++; $display("FAIL rst_cur_mode got %0d want 0", cur_mode); end
    checks++; if (tbl_idx !== 3'd0) begin failures++; $display("FAIL rst_tbl_idx got %0d want 0", tbl_idx); end
    checks++; if (tbl_mode !== 2'd0) begin failures++; $display("FAIL rst_tbl_mode got %0d want 0", tbl_mode); end
    reset = 1'b0;
    w0 = wr_seen; b0 = busy_cnt;
    repeat (200) step();
    checks++; if (wr_seen != w0) begin failures++; $display("FAIL idle_no_write got %0d strobes want 0", wr_seen - w0); end
    checks++; if (busy_cnt != b0) begin failures++; $display("FAIL idle_no_busy got %0d busy cycles want 0", busy_cnt - b0); end
  endtask

  task automatic test_mode_change();
    int base, b0, c0;
    base = wq_addr.size(); b0 = busy_cnt; c0 = cr_mis;
    mode_in = 2'd1;
    step(); step();
    checks++; if (mgmt_write !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mc_early got write=%b busy=%b want 0/0", mgmt_write, busy); end
    step();
    checks++; if (mgmt_write !== 1'b1 || mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0)
      begin failures++; $display("FAIL mc_arm got write=%b addr=%0d data=%h want 1/0/0", mgmt_write, mgmt_address, mgmt_writedata); end
    checks++; if (core_reset !== 1'b1 || busy !== 1'b1 || tbl_mode !== 2'd1)
      begin failures++; $display("FAIL mc_arm_ctl got core_reset=%b busy=%b tbl_mode=%0d want 1/1/1", core_reset, busy, tbl_mode); end
    for (int k = 0; k < 200 && busy; k++) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mc_timeout got busy=%b want 0", busy); end
    checks++; if (wq_addr.size() != base + 6) begin failures++; $display("FAIL mc_count got %0d writes want 6", wq_addr.size() - base); end
    if (wq_addr.size() == base + 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (int'(wq_addr[base+i]) != exp_a[1][i] || wq_data[base+i] !== exp_d[1][i])
          begin failures++; $display("FAIL mc_write%0d got %0d/%h want %0d/%h", i, wq_addr[base+i], wq_data[base+i], exp_a[1][i], exp_d[1][i]); end
      end
      checks++; if (wq_cyc[base+5] - wq_cyc[base] != 5) begin failures++; $display("FAIL mc_b2b got span %0d want 5", wq_cyc[base+5] - wq_cyc[base]); end
    end
    checks++; if (busy_cnt - b0 != SEQ_CYC) begin failures++; $display("FAIL mc_seq_len got %0d want %0d", busy_cnt - b0, SEQ_CYC); end
    checks++; if (cr_mis != c0) begin failures++; $display("FAIL mc_core_reset got %0d mismatched cycles want 0", cr_mis - c0); end
    checks++; if (cur_mode !== 2'd1 || core_reset !== 1'b0 || tbl_idx !== 3'd0)
      begin failures++; $display("FAIL mc_end got cur_mode=%0d core_reset=%b tbl_idx=%0d want 1/0/0", cur_mode, core_reset, tbl_idx); end
  endtask

  task automatic test_waitrequest();
    int base, b0;
    base = wq_addr.size(); b0 = busy_cnt;
    mode_in = 2'd0;
    for (int k = 0; k < 20 && !(mgmt_write && mgmt_address == 6'd9); k++) step();
    checks++; if (!(mgmt_write && mgmt_address == 6'd9)) begin failures++; $display("FAIL wr_find got addr=%0d want 9", mgmt_address); end
    mgmt_waitrequest = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (mgmt_write !== 1'b1 || mgmt_address !== 6'd9 || mgmt_writedata !== 32'hC0DE0001)
        begin failures++; $display("FAIL wr_hold%0d got %b/%0d/%h want 1/9/c0de0001", i, mgmt_write, mgmt_address, mgmt_writedata); end
    end
    mgmt_waitrequest = 1'b0;
    for (int k = 0; k < 200 && busy; k++) step();
    checks++; if (wq_addr.size() != base + 6) begin failures++; $display("FAIL wr_count got %0d writes want 6", wq_addr.size() - base); end
    if (wq_addr.size() == base + 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (int'(wq_addr[base+i]) != exp_a[0][i] || wq_data[base+i] !== exp_d[0][i])
          begin failures++; $display("FAIL wr_write%0d got %0d/%h want %0d/%h", i, wq_addr[base+i], wq_data[base+i], exp_a[0][i], exp_d[0][i]); end
      end
    end
    checks++; if (busy_cnt - b0 != SEQ_CYC + 3) begin failures++; $display("FAIL wr_seq_len got %0d want %0d", busy_cnt - b0, SEQ_CYC + 3); end
    checks++; if (cur_mode !== 2'd0) begin failures++; $display("FAIL wr_cur_mode got %0d want 0", cur_mode); end
  endtask

  task automatic test_toggle();
    int base, b0;
    base = wq_addr.size(); b0 = busy_cnt;
    mode_in = 2'd1;
    for (int k = 0; k < 20 && !(mgmt_write && mgmt_address == 6'd17); k++) step();
    mode_in = 2'd0;
    repeat (120) step();
    checks++; if (wq_addr.size() != base + 12) begin failures++; $display("FAIL tg_count got %0d writes want 12", wq_addr.size() - base); end
    if (wq_addr.size() == base + 12) begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (int'(wq_addr[base+i]) != exp_a[i < 6 ? 1 : 0][i % 6] || wq_data[base+i] !== exp_d[i < 6 ? 1 : 0][i % 6])
          begin failures++; $display("FAIL tg_write%0d got %0d/%h want %0d/%h", i, wq_addr[base+i], wq_data[base+i],
                                      exp_a[i < 6 ? 1 : 0][i % 6], exp_d[i < 6 ? 1 : 0][i % 6]); end
      end
    end
    checks++; if (busy_cnt - b0 != 2 * SEQ_CYC) begin failures++; $display("FAIL tg_seq_len got %0d want %0d", busy_cnt - b0, 2 * SEQ_CYC); end
    checks++; if (cur_mode !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL tg_end got cur_mode=%0d busy=%b want 0/0", cur_mode, busy); end
  endtask

  task automatic test_invalid_mode();
    int w0;
    w0 = wr_seen;
    mode_in = 2'd3;
    repeat (30) step();
    checks++; if (wr_seen != w0 || busy !== 1'b0) begin failures++; $display("FAIL inv_ignored got %0d strobes busy=%b want 0/0", wr_seen - w0, busy); end
    checks++; if (cur_mode !== 2'd0) begin failures++; $display("FAIL inv_cur_mode got %0d want 0", cur_mode); end
  endtask

  task automatic test_reset_mid();
    int base;
    mode_in = 2'd1;
    for (int k = 0; k < 20 && !(mgmt_write && mgmt_address == 6'd18); k++) step();
    checks++; if (!(mgmt_write && mgmt_address == 6'd18)) begin failures++; $display("FAIL rm_find got addr=%0d want 18", mgmt_address); end
    reset = 1'b1;
    step();
    checks++;
    if (mgmt_write !== 1'b0 || mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0 || core_reset !== 1'b0 || busy !== 1'b0 ||
        cur_mode !== 2'd0 || tbl_idx !== 3'd0 || tbl_mode !== 2'd0 || lock_err !== 1'b0)
      begin failures++; $display("FAIL rm_values got w=%b a=%0d d=%h cr=%b b=%b cm=%0d ti=%0d tm=%0d le=%b want all reset values",
                                 mgmt_write, mgmt_address, mgmt_writedata, core_reset, busy, cur_mode, tbl_idx, tbl_mode, lock_err); end
    reset = 1'b0;
    base = wq_addr.size();
    step(); step();
    checks++; if (mgmt_write !== 1'b0) begin failures++; $display("FAIL rm_early got write=%b want 0", mgmt_write); end
    step();
    checks++; if (mgmt_write !== 1'b1 || mgmt_address !== 6'd0 || busy !== 1'b1)
      begin failures++; $display("FAIL rm_rearm got write=%b addr=%0d busy=%b want 1/0/1", mgmt_write, mgmt_address, busy); end
    for (int k = 0; k < 200 && busy; k++) step();
    checks++; if (wq_addr.size() != base + 6) begin failures++; $display("FAIL rm_count got %0d writes want 6", wq_addr.size() - base); end
    if (wq_addr.size() == base + 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (int'(wq_addr[base+i]) != exp_a[1][i] || wq_data[base+i] !== exp_d[1][i])
          begin failures++; $display("FAIL rm_write%0d got %0d/%h want %0d/%h", i, wq_addr[base+i], wq_data[base+i], exp_a[1][i], exp_d[1][i]); end
      end
    end
    checks++; if (cur_mode !== 2'd1) begin failures++; $display("FAIL rm_cur_mode got %0d want 1", cur_mode); end
  endtask

`ifdef PLLCFG_LOCK_WAIT_EN
  task automatic test_lock_timeout();
    int b0;
    b0 = busy_cnt;
    pll_locked = 1'b0;
    mode_in = 2'd0;
    repeat (150) step();
    checks++; if (busy_cnt - b0 != 1 + 4 + 1 + LOCK_TIMEOUT + 1)
      begin failures++; $display("FAIL lt_seq_len got %0d want %0d", busy_cnt - b0, 1 + 4 + 1 + LOCK_TIMEOUT + 1); end
    checks++; if (lock_err !== 1'b1 || core_reset !== 1'b0 || cur_mode !== 2'd0)
      begin failures++; $display("FAIL lt_end got lock_err=%b core_reset=%b cur_mode=%0d want 1/0/0", lock_err, core_reset, cur_mode); end
    pll_locked = 1'b1;
    repeat (10) step();
    checks++; if (lock_err !== 1'b1) begin failures++; $display("FAIL lt_sticky got %b want 1", lock_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_mode_change();
    test_waitrequest();
    test_toggle();
    test_invalid_mode();
    test_reset_mid();
`ifdef PLLCFG_LOCK_WAIT_EN
    test_lock_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
